// File: rtl/al_accel_bpfeed.sv
// Bypass-buffer feeder: a small word FIFO in front of the accelerator bpbuf.
// Loads one word into bpbuf, holds it until the datapath consumes it, then loads the next.
module al_accel_bpfeed #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    input  logic             consume,
    output logic [WIDTH-1:0] bpbuf_di,
    output logic             bpbuf_ld_wrn,
    output logic             bpbuf_enb,
    output logic             held,
    output logic             frame_done,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            last_held_q, last_held_d;
    logic [WIDTH:0]  mem_q [DEPTH];
    logic [WIDTH:0]  head;
    logic            push, pop;

    assign head    = mem_q[rd_ptr_q];
    assign s_ready = !reset && !flush && (count_q < FULL);
    assign push    = s_valid && s_ready;
    assign pop     = (state_q == LOAD) && !flush;

    assign count        = count_q;
    assign bpbuf_di     = (count_q != '0) ? head[WIDTH-1:0] : '0;
    assign held         = (state_q == HOLD);
    assign bpbuf_enb    = pop;
    assign bpbuf_ld_wrn = pop;
    assign frame_done   = (state_q == HOLD) && consume && last_held_q && !flush;

    // Storage has no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {s_last, s_data};
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        last_held_d = last_held_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            last_held_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + 1'b1;
                last_held_d = head[WIDTH];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // A word pushed into an empty FIFO starts loading on the same edge it lands.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (count_q != '0 || push) state_d = LOAD;
                LOAD: state_d = HOLD;
                HOLD: if (consume) state_d = (count_q != '0 || push) ? LOAD : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_held_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_held_q <= last_held_d;
        end
    end

endmodule

// File: tb/tb_al_accel_bpfeed.sv
// Directed bench for al_accel_bpfeed: load/hold/consume flow, FIFO full/wrap, flush, async reset.
module tb_al_accel_bpfeed;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        consume = 1'b0;
    logic [31:0] bpbuf_di;
    logic        bpbuf_ld_wrn;
    logic        bpbuf_enb;
    logic        held;
    logic        frame_done;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    al_accel_bpfeed #(.DEPTH(4), .WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .consume(consume), .bpbuf_di(bpbuf_di), .bpbuf_ld_wrn(bpbuf_ld_wrn),
        .bpbuf_enb(bpbuf_enb), .held(held), .frame_done(frame_done), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Snapshot of the observable state: held, enb, ld_wrn, count, data.
    task automatic chk_st(input string tag, input logic h, input logic ld,
                          input logic [2:0] c, input logic [31:0] d);
        chk({tag, ".held"},  64'(held), 64'(h));
        chk({tag, ".enb"},   64'(bpbuf_enb), 64'(ld));
        chk({tag, ".ldwrn"}, 64'(bpbuf_ld_wrn), 64'(ld));
        chk({tag, ".count"}, 64'(count), 64'(c));
        chk({tag, ".di"},    64'(bpbuf_di), 64'(d));
    endtask

    logic [31:0] w [6];

    initial begin
        w[0] = 32'hA000_0001; w[1] = 32'hB000_0002; w[2] = 32'hC000_0003;
        w[3] = 32'hD000_0004; w[4] = 32'hE000_0005; w[5] = 32'hF000_0006;

        // Reset state
        #1;
        chk_st("rst", 1'b0, 1'b0, 3'd0, 32'h0);
        chk("rst.s_ready", 64'(s_ready), 64'd0);
        chk("rst.frame_done", 64'(frame_done), 64'd0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rel.s_ready", 64'(s_ready), 64'd1);

        // 1. Single word with last tag
        s_valid = 1'b1; s_data = 32'hDEADBEEF; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0; #1;
        chk_st("t1.load", 1'b0, 1'b1, 3'd1, 32'hDEADBEEF);
        tick(); #1;
        chk_st("t1.hold", 1'b1, 1'b0, 3'd0, 32'h0);
        consume = 1'b1; #1;
        chk("t1.frame_done", 64'(frame_done), 64'd1);
        tick();
        consume = 1'b0; #1;
        chk_st("t1.idle", 1'b0, 1'b0, 3'd0, 32'h0);
        chk("t1.fd_clear", 64'(frame_done), 64'd0);

        // 2. Fill to DEPTH behind a held word, then drain with wrap
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = w[i];
            tick();
        end
        s_data = w[5]; #1;
        chk_st("t2.full", 1'b1, 1'b0, 3'd4, w[1]);
        chk("t2.s_ready_full", 64'(s_ready), 64'd0);
        tick();
        s_valid = 1'b0; #1;
        chk("t2.blocked_count", 64'(count), 64'd4);
        for (int i = 1; i < 5; i++) begin
            consume = 1'b1;
            tick();
            consume = 1'b0; #1;
            chk_st($sformatf("t2.load%0d", i), 1'b0, 1'b1, 3'(5 - i), w[i]);
            tick(); #1;
            chk("t2.held", 64'(held), 64'd1);
            chk("t2.count", 64'(count), 64'(4 - i));
        end
        consume = 1'b1; #1;
        chk("t2.no_fd", 64'(frame_done), 64'd0);
        tick();
        consume = 1'b0; #1;
        chk_st("t2.idle", 1'b0, 1'b0, 3'd0, 32'h0);

        // 4a. consume in IDLE ignored
        consume = 1'b1; #1;
        chk("t4.idle_fd", 64'(frame_done), 64'd0);
        tick();
        consume = 1'b0; #1;
        chk_st("t4.idle_stay", 1'b0, 1'b0, 3'd0, 32'h0);

        // 3. Push coinciding with a LOAD pop keeps count
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = w[i];
            tick();
        end
        s_valid = 1'b0; #1;
        chk_st("t3.pre", 1'b1, 1'b0, 3'd2, w[1]);
        consume = 1'b1;
        tick(); #1;
        // 4b. consume held high during LOAD, with a push on the pop edge
        s_valid = 1'b1; s_data = w[3]; s_last = 1'b1; #1;
        chk_st("t3.load", 1'b0, 1'b1, 3'd2, w[1]);
        chk("t4.load_fd", 64'(frame_done), 64'd0);
        tick();
        s_valid = 1'b0; s_last = 1'b0; consume = 1'b0; #1;
        chk_st("t3.same_count", 1'b1, 1'b0, 3'd2, w[2]);

        // 5. flush during LOAD with count=3
        s_valid = 1'b1; s_data = w[4];
        tick();
        s_valid = 1'b0; consume = 1'b1;
        tick();
        consume = 1'b0; #1;
        chk_st("t5.load", 1'b0, 1'b1, 3'd3, w[2]);
        flush = 1'b1; s_valid = 1'b1; s_data = w[5]; #1;
        chk("t5.enb_supp", 64'(bpbuf_enb), 64'd0);
        chk("t5.ldwrn_supp", 64'(bpbuf_ld_wrn), 64'd0);
        chk("t5.s_ready", 64'(s_ready), 64'd0);
        tick();
        flush = 1'b0; s_valid = 1'b0; #1;
        chk_st("t5.after", 1'b0, 1'b0, 3'd0, 32'h0);
        tick(); #1;
        chk_st("t5.idle", 1'b0, 1'b0, 3'd0, 32'h0);

        // 6. Async reset mid-HOLD with count=2
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = w[i];
            tick();
        end
        s_valid = 1'b0; #1;
        chk_st("t6.pre", 1'b1, 1'b0, 3'd2, w[1]);
        consume = 1'b1;
        reset = 1'b1; #1;
        chk_st("t6.rst", 1'b0, 1'b0, 3'd0, 32'h0);
        chk("t6.s_ready", 64'(s_ready), 64'd0);
        chk("t6.fd", 64'(frame_done), 64'd0);
        consume = 1'b0;
        tick();
        reset = 1'b0;
        s_valid = 1'b1; s_data = 32'h12345678; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0; #1;
        chk_st("t6.load", 1'b0, 1'b1, 3'd1, 32'h12345678);
        tick(); #1;
        chk_st("t6.hold", 1'b1, 1'b0, 3'd0, 32'h0);
        consume = 1'b1; #1;
        chk("t6.fd", 64'(frame_done), 64'd1);
        tick();
        consume = 1'b0; #1;
        chk("t6.idle_held", 64'(held), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
